pipelined_ternary_adder_tree: RTL and testbench
===============================================

Name: pipelined_ternary_adder_tree

Overview:
- Fully pipelined unsigned summation tree that adds NUM_INPUTS operands of W bits each and produces one wide sum.
- Built from registered 3-input adder cells. Each cell is a carry-save 3:2 compressor followed by a carry-propagate adder, so operands reduce by three per level.
- Used as a reduction back-end wherever many per-lane counters or partial results must be totalled.
- Accepts a new operand set every clock cycle.

Parameters:
- W, 16: width of each unsigned input operand.
- NUM_INPUTS, 200: number of operands, minimum 1.
- SUM_W, W+NUM_INPUTS-1 (derived, not overridable): width of total_sum.
- LEVELS, max(1, ceil(log3(NUM_INPUTS))) (derived): number of tree levels, which equals the latency in cycles.

Ports:
- clock  input  1  rising-edge clock for all registers.
- reset_n  input  1  asynchronous, active-low reset.
- inputs  input  NUM_INPUTS x W  unpacked array of unsigned operands, sampled every cycle.
- total_sum  output  SUM_W  registered unsigned sum of all operands.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- reset_n = 0 immediately clears every pipeline register, including total_sum, to 0, with no clock needed.
- Release of reset takes effect synchronously at the next rising clock edge.
- Cell function: out = a + b + c on W_in-bit unsigned operands, giving a W_in+2-bit result.
  - Combinational path: sum/carry vectors from a full-adder row, then a single carry-propagate add.
  - The result is registered, so each cell has 1 cycle latency.
- Level 0 groups inputs in index order: {0,1,2}, {3,4,5}, and so on.
- Each following level groups the previous level's outputs the same way.
- When a level's operand count is not a multiple of 3, missing cell operands are tied to 0.
- A lone leftover operand may use a cell with two zero operands, or be delayed through one register. Either way all paths in a level have equal latency.
- Node width grows by 2 bits per level. The final node is zero-extended or truncated to SUM_W. This is lossless, because the true sum needs at most W+ceil(log2 NUM_INPUTS) bits and that is ≤ SUM_W for all NUM_INPUTS ≥ 1.
- NUM_INPUTS = 1: total_sum is inputs[0] zero-extended, registered, with latency 1.
- Latency: total_sum at cycle t+LEVELS equals the sum of the inputs sampled at edge t.
  - Example: W=16, N=200 gives LEVELS=5.
- Throughput: one result per cycle, with no stalls, no valid/ready and no handshake.
- During the first LEVELS cycles after reset release, total_sum carries partial sums of zeroed stages.
  - It is guaranteed correct once LEVELS edges have passed with stable inputs.
- No arithmetic overflow is possible. Inputs are unsigned only.
- Reset mid-stream: all in-flight sums are discarded and the output returns to 0 at once.
  - The first valid result after reset is from the inputs sampled at the first post-reset edge, appearing LEVELS cycles later.
- All logic is synthesizable, with generate-based tree construction from the parameters.

Test Plan:
- W=16, N=200, inputs[i]=i+32767, reset released, hold 10 cycles -> total_sum = 6573300. It is also exactly 6573300 at cycle 5 after the first sampled edge.
- W=16, N=200, all inputs 0xFFFF -> total_sum = 13107000 after 5 cycles, with no truncation.
- W=32, N=3 (LEVELS=1), stream one set per cycle:
  - (1,2,3) -> 6
  - (10,12,13) -> 35
  - (15,15,15) twice -> 45, 45
  - (115,123,145) -> 383
  - (275,324,454) -> 1053
  - (24750,32324,45354) -> 102428
  - Each result appears one cycle after its set is sampled.
- Reset mid-stream, W=16 N=200: assert reset_n=0 asynchronously between edges -> total_sum = 0 immediately.
  - Release and apply inputs[i]=1 -> total_sum = 200 after 5 cycles, with no residue of the earlier data.
- Edge builds:
  - N=1, W=8, input 0xAB -> 0xAB after 1 cycle.
  - N=2, W=8, inputs 0xFF,0xFF -> 0x1FE after 1 cycle.
  - N=4, W=8, all 0xFF -> 0x3FC after 2 cycles.
- Random streaming, W=16, N=200, 1000 cycles of random inputs: compare against a scoreboard delayed by LEVELS cycles -> zero mismatches.

Source files
------------

// File: rtl/pipelined_ternary_adder_tree.sv
// Pipelined unsigned reduction tree built from registered 3-input adder cells.
// Each level reduces its operand count by three and adds one cycle of latency.

module ternary_add_cell #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  input  logic [IN_W-1:0]  i_c,
  output logic [OUT_W-1:0] o_sum
);
  localparam int unsigned EXT_W = IN_W + 2;

  logic [IN_W-1:0]  w_save;
  logic [IN_W-1:0]  w_carry;
  logic [OUT_W-1:0] w_sum;

  // Full-adder row (3:2 compressor) followed by one carry-propagate add
  assign w_save  = i_a ^ i_b ^ i_c;
  assign w_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign w_sum   = OUT_W'(EXT_W'(w_save) + (EXT_W'(w_carry) << 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) o_sum <= '0;
    else          o_sum <= w_sum;
  end
endmodule

module pipelined_ternary_adder_tree #(
  parameter  int unsigned W          = 16,
  parameter  int unsigned NUM_INPUTS = 200,
  localparam int unsigned SUM_W      = W + NUM_INPUTS - 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [W-1:0]     inputs [NUM_INPUTS],
  output logic [SUM_W-1:0] total_sum
);
  function automatic int unsigned calc_levels(int unsigned n);
    int unsigned lv = 0;
    int unsigned p  = 1;
    while (p < n) begin
      p  = p * 3;
      lv = lv + 1;
    end
    return (lv == 0) ? 1 : lv;
  endfunction

  // Operand count entering level l: ceil(NUM_INPUTS / 3^l)
  function automatic int unsigned lvl_in_cnt(int unsigned l);
    int unsigned c = NUM_INPUTS;
    for (int unsigned k = 0; k < l; k++) c = (c + 2) / 3;
    return c;
  endfunction

  // Node width grows by 2 per level, capped at SUM_W since partial sums always fit there
  function automatic int unsigned node_w(int unsigned l);
    int unsigned nw = W + 2 * (l + 1);
    return (nw < SUM_W) ? nw : SUM_W;
  endfunction

  function automatic int unsigned lvl_in_w(int unsigned l);
    if (l == 0) return W;
    return node_w(l - 1);
  endfunction

  localparam int unsigned LEVELS = calc_levels(NUM_INPUTS);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned IN_CNT  = lvl_in_cnt(l);
    localparam int unsigned OUT_CNT = (IN_CNT + 2) / 3;
    localparam int unsigned IN_W    = lvl_in_w(l);
    localparam int unsigned OUT_W   = node_w(l);

    logic [IN_W-1:0]  w_opd  [3*OUT_CNT];
    logic [OUT_W-1:0] r_node [OUT_CNT];

    // Operands past the end of this level are tied to zero
    for (genvar j = 0; j < 3 * OUT_CNT; j++) begin : g_opd
      if (j >= IN_CNT) begin : g_zero
        assign w_opd[j] = '0;
      end else if (l == 0) begin : g_leaf
        assign w_opd[j] = inputs[j];
      end else begin : g_inner
        assign w_opd[j] = g_lvl[l-1].r_node[j];
      end
    end

    for (genvar k = 0; k < OUT_CNT; k++) begin : g_cell
      ternary_add_cell #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_cell (
        .clock   (clock),
        .reset_n (reset_n),
        .i_a     (w_opd[3*k]),
        .i_b     (w_opd[3*k+1]),
        .i_c     (w_opd[3*k+2]),
        .o_sum   (r_node[k])
      );
    end
  end

  assign total_sum = SUM_W'(g_lvl[LEVELS-1].r_node[0]);
endmodule

// File: tb/tb_pipelined_ternary_adder_tree.sv
// Directed and scoreboard checks for pipelined_ternary_adder_tree across several builds.

module tb_pipelined_ternary_adder_tree;
  logic clock;
  logic reset_n;

  logic [15:0]  in_main [200];
  logic [214:0] sum_main;
  logic [31:0]  in_n3 [3];
  logic [33:0]  sum_n3;
  logic [7:0]   in_n1 [1];
  logic [7:0]   sum_n1;
  logic [7:0]   in_n2 [2];
  logic [8:0]   sum_n2;
  logic [7:0]   in_n4 [4];
  logic [10:0]  sum_n4;

  int n_checks;
  int n_errors;
  longint exp_q [$];

  pipelined_ternary_adder_tree #(.W(16), .NUM_INPUTS(200)) u_dut (
    .clock(clock), .reset_n(reset_n), .inputs(in_main), .total_sum(sum_main));
  pipelined_ternary_adder_tree #(.W(32), .NUM_INPUTS(3)) u_n3 (
    .clock(clock), .reset_n(reset_n), .inputs(in_n3), .total_sum(sum_n3));
  pipelined_ternary_adder_tree #(.W(8), .NUM_INPUTS(1)) u_n1 (
    .clock(clock), .reset_n(reset_n), .inputs(in_n1), .total_sum(sum_n1));
  pipelined_ternary_adder_tree #(.W(8), .NUM_INPUTS(2)) u_n2 (
    .clock(clock), .reset_n(reset_n), .inputs(in_n2), .total_sum(sum_n2));
  pipelined_ternary_adder_tree #(.W(8), .NUM_INPUTS(4)) u_n4 (
    .clock(clock), .reset_n(reset_n), .inputs(in_n4), .total_sum(sum_n4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] v3   [7][3] = '{'{32'd1, 32'd2, 32'd3}, '{32'd10, 32'd12, 32'd13},
                               '{32'd15, 32'd15, 32'd15}, '{32'd15, 32'd15, 32'd15},
                               '{32'd115, 32'd123, 32'd145}, '{32'd275, 32'd324, 32'd454},
                               '{32'd24750, 32'd32324, 32'd45354}};
  logic [33:0] exp3 [7]    = '{34'd6, 34'd35, 34'd45, 34'd45, 34'd383, 34'd1053, 34'd102428};

  initial begin
    longint s;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    for (int i = 0; i < 200; i++) in_main[i] = '0;
    for (int i = 0; i < 3; i++)   in_n3[i]   = '0;
    in_n1[0] = '0;
    for (int i = 0; i < 2; i++)   in_n2[i]   = '0;
    for (int i = 0; i < 4; i++)   in_n4[i]   = '0;
    repeat (2) tick();

    check_eq("reset_main", 256'(sum_main), 256'd0);
    check_eq("reset_n3",   256'(sum_n3),   256'd0);
    check_eq("reset_n1",   256'(sum_n1),   256'd0);
    check_eq("reset_n2",   256'(sum_n2),   256'd0);
    check_eq("reset_n4",   256'(sum_n4),   256'd0);

    // Ramp operands; release reset between edges, result lands exactly 5 edges later
    for (int i = 0; i < 200; i++) in_main[i] = 16'(i + 32767);
    reset_n = 1'b1;
    repeat (4) tick();
    check_eq("ramp_lat4", 256'(sum_main), 256'd0);
    tick();
    check_eq("ramp_lat5", 256'(sum_main), 256'd6573300);
    repeat (5) tick();
    check_eq("ramp_hold10", 256'(sum_main), 256'd6573300);

    for (int i = 0; i < 200; i++) in_main[i] = 16'hFFFF;
    repeat (5) tick();
    check_eq("all_ones", 256'(sum_main), 256'd13107000);

    // N=3 stream: one set per cycle, result one edge later
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 3; i++) in_n3[i] = v3[k][i];
      tick();
      check_eq($sformatf("n3_set%0d", k), 256'(sum_n3), 256'(exp3[k]));
    end

    in_n1[0] = 8'hAB;
    in_n2[0] = 8'hFF;
    in_n2[1] = 8'hFF;
    for (int i = 0; i < 4; i++) in_n4[i] = 8'hFF;
    tick();
    check_eq("n1_ab",   256'(sum_n1), 256'h0AB);
    check_eq("n2_ff",   256'(sum_n2), 256'h1FE);
    tick();
    check_eq("n4_ff",   256'(sum_n4), 256'h3FC);

    // Random streaming against a LEVELS-deep scoreboard
    exp_q.delete();
    for (int c = 0; c < 1000; c++) begin
      s = 0;
      for (int i = 0; i < 200; i++) begin
        in_main[i] = (c % 97 == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        s = s + longint'(in_main[i]);
      end
      exp_q.push_back(s);
      tick();
      if (exp_q.size() == 5) check_eq("rand", 256'(sum_main), 256'(exp_q.pop_front()));
    end

    // Asynchronous reset mid-stream, between edges
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_main", 256'(sum_main), 256'd0);
    check_eq("async_rst_n3",   256'(sum_n3),   256'd0);
    for (int i = 0; i < 200; i++) in_main[i] = 16'd1;
    #1;
    reset_n = 1'b1;
    repeat (4) tick();
    check_eq("post_rst_lat4", 256'(sum_main), 256'd0);
    tick();
    check_eq("post_rst_ones", 256'(sum_main), 256'd200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
